// File: rtl/cu_reorder_out_pkg.sv
// FFT pipeline shared definitions: frame size, read FSM states,
// and the bit-reversal helper used by the reorder stages.
package fft_pkg;
  localparam int N_PTS = 512;
  localparam int ADDR_W = 9;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_PTS - 1);

  typedef enum logic {
    IDLE,
    READ
  } rd_state_t;

  function automatic logic [ADDR_W-1:0] bitrev(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++)
      r[i] = a[ADDR_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/cu_reorder_out_if.sv
// Reorder-output control bundle: sample-valid/backpressure
// inputs and the ping-pong buffer write/read controls.
interface cu_reorder_out_if;
  import fft_pkg::*;

  logic              alert_in;
  logic              out_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_bank;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bank;
  logic              dout_valid;
  logic              frame_done;
  logic              overflow;

  modport slave (
    input  alert_in, out_ready,
    output wr_en, wr_addr, wr_bank,
    output rd_en, rd_addr, rd_bank,
    output dout_valid, frame_done, overflow
  );

  modport master (
    output alert_in, out_ready,
    input  wr_en, wr_addr, wr_bank,
    input  rd_en, rd_addr, rd_bank,
    input  dout_valid, frame_done, overflow
  );
endinterface

// File: rtl/cu_reorder_out_addr_gen.sv
// Natural-order frame address counter, wrapping at N_PTS-1.
module addr_gen
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt_q <= '0;
    else if (en)
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  assign addr = cnt_q;
endmodule

// File: rtl/cu_reorder_out.sv
// Output reorder control: natural-order ping-pong writes,
// bit-reversed readout with downstream backpressure.
module cu_reorder_out
  import fft_pkg::*;
(
  input logic             clk,
  input logic             rstn,
  cu_reorder_out_if.slave io
);
  rd_state_t         state_q, state_d;
  logic              wr_en_q;
  logic              wr_bank_q, wr_bank_d;
  logic [1:0]        full_q, full_d;
  logic              ovf_q;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              rd_bank_q, rd_bank_d;
  logic              dv_q, fd_q;
  logic [ADDR_W-1:0] wr_cnt;
  logic              wr_last, rd_en, rd_last;
  logic              wr_acc, wr_ovf;

  addr_gen u_wr_cnt (
    .clk  (clk),
    .rstn (rstn),
    .en   (wr_en_q),
    .addr (wr_cnt)
  );

  // Acceptance looks at the bank the write will land in, so a
  // bank freed this cycle is writable on the very next one.
  always_comb begin
    wr_last   = wr_en_q && (wr_cnt == LAST);
    rd_en     = (state_q == READ) && io.out_ready;
    rd_last   = rd_en && (rd_cnt_q == LAST);
    full_d    = full_q;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
    wr_bank_d = wr_bank_q ^ wr_last;
    rd_bank_d = rd_bank_q ^ rd_last;
    wr_acc    = io.alert_in && !full_d[wr_bank_d];
    wr_ovf    = io.alert_in && full_d[wr_bank_d];
    rd_cnt_d  = rd_en ? rd_cnt_q + 1'b1 : rd_cnt_q;
    state_d   = state_q;
    unique case (state_q)
      IDLE: if (full_q[rd_bank_q]) state_d = READ;
      READ: if (rd_last) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
      ovf_q     <= 1'b0;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      dv_q      <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_acc;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      ovf_q     <= ovf_q | wr_ovf;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
      dv_q      <= rd_en;
      fd_q      <= rd_last;
    end
  end

  assign io.wr_en      = wr_en_q;
  assign io.wr_addr    = wr_cnt;
  assign io.wr_bank    = wr_bank_q;
  assign io.rd_en      = rd_en;
  assign io.rd_addr    = bitrev(rd_cnt_q);
  assign io.rd_bank    = rd_bank_q;
  assign io.dout_valid = dv_q;
  assign io.frame_done = fd_q;
  assign io.overflow   = ovf_q;
endmodule

// File: tb/tb_cu_reorder_out.sv
// Bench for cu_reorder_out: randomized and directed traffic
// against a frame-count reference model.
module tb_cu_reorder_out;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cu_reorder_out_if bus();

  cu_reorder_out dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int fd_cyc = -1;

  // Reference: totals of samples written/read and unread frames.
  int m_wr, m_rd, m_full;
  bit m_wr_en, m_reading, m_ovf, m_dv, m_fd;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < 9; i++)
      if ((v >> i) & 1) r = r + (1 << (8 - i));
    return r;
  endfunction

  function automatic logic [24:0] dut_vec();
    return {bus.wr_en, bus.wr_addr, bus.wr_bank,
            bus.rd_en, bus.rd_addr, bus.rd_bank,
            bus.dout_valid, bus.frame_done, bus.overflow};
  endfunction

  function automatic logic [24:0] exp_vec(input bit r);
    logic [8:0] wa, ra;
    logic wb, rb;
    wa = 9'(m_wr % 512);
    wb = 1'((m_wr / 512) % 2);
    ra = 9'(brev(m_rd % 512));
    rb = 1'((m_rd / 512) % 2);
    return {m_wr_en, wa, wb, m_reading & r, ra, rb,
            m_dv, m_fd, m_ovf};
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_full = 0;
    m_wr_en = 0; m_reading = 0; m_ovf = 0;
    m_dv = 0; m_fd = 0;
  endtask

  task automatic model_update(input bit a, input bit r);
    bit rde, wl, rl, nxt;
    int nf;
    rde = m_reading && r;
    wl = m_wr_en && (m_wr % 512 == 511);
    rl = rde && (m_rd % 512 == 511);
    nf = m_full + int'(wl) - int'(rl);
    nxt = m_reading ? !rl : (m_full > 0);
    if (a && nf == 2) m_ovf = 1;
    m_wr = m_wr + int'(m_wr_en);
    m_wr_en = a && (nf < 2);
    m_rd = m_rd + int'(rde);
    m_full = nf;
    m_dv = rde;
    m_fd = rl;
    m_reading = nxt;
  endtask

  task automatic step(input bit a, input bit r);
    @(negedge clk);
    bus.alert_in = a;
    bus.out_ready = r;
    #1;
    check("outs", 32'(dut_vec()), 32'(exp_vec(r)));
    if (bus.frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    @(posedge clk);
    model_update(a, r);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rstn = 1'b0;
      bus.alert_in = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      check("rst", 32'(dut_vec()), 32'd0);
      model_reset();
    end
    @(negedge clk);
    bus.alert_in = 1'b0;
    bus.out_ready = 1'b0;
    rstn = 1'b1;
  endtask

  initial begin
    int c0, base;
    bus.alert_in = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    do_reset(5);
    for (int i = 0; i < 10; i++) step(0, 1'($urandom_range(0, 1)));

    // single frame
    fd_cnt = 0;
    c0 = cyc;
    for (int i = 0; i < 512; i++) step(1, 1);
    for (int i = 0; i < 600; i++) step(0, 1);
    check("single_fd_cnt", 32'(fd_cnt), 32'd1);
    check("single_fd_cyc", 32'(fd_cyc), 32'(c0 + 1026));

    // back-to-back frames
    fd_cnt = 0;
    for (int i = 0; i < 1024; i++) step(1, 1);
    for (int i = 0; i < 1200; i++) step(0, 1);
    check("b2b_fd_cnt", 32'(fd_cnt), 32'd2);
    check("b2b_ovf", 32'(bus.overflow), 32'd0);

    // gapped input
    fd_cnt = 0;
    for (int i = 0; i < 200; i++) step(1, 1);
    for (int i = 0; i < 10; i++) step(0, 1);
    check("gap_hold", 32'(bus.wr_addr), 32'd200);
    for (int i = 0; i < 312; i++) step(1, 1);
    for (int i = 0; i < 600; i++) step(0, 1);
    check("gap_fd_cnt", 32'(fd_cnt), 32'd1);

    // backpressure then third frame overflow
    fd_cnt = 0;
    base = cyc;
    for (int i = 0; i < 1536; i++) step(1, 1'((cyc - base) % 2));
    check("bp_ovf", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 2400; i++) step(0, 1'((cyc - base) % 2));
    check("bp_fd_cnt", 32'(fd_cnt), 32'd2);

    // randomized traffic
    do_reset(3);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60);

    // reset mid-read
    do_reset(2);
    for (int i = 0; i < 512; i++) step(1, 1);
    for (int i = 0; i < 200 && !(m_reading && m_rd == 100); i++)
      step(0, 1);
    check("midrd_reached", 32'(m_rd), 32'd100);
    do_reset(2);
    fd_cnt = 0;
    for (int i = 0; i < 700; i++) step(0, 1);
    check("midrd_fd_cnt", 32'(fd_cnt), 32'd0);
    check("midrd_rd_addr", 32'(bus.rd_addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cu_reorder_out.md
# cu_reorder_out

Output-side control unit of the 512-point FFT pipeline. It accepts the stage-valid `alert` level from the last butterfly control unit, which asserts it for one sample per cycle. It generates write controls for a two-bank (ping-pong) output buffer in natural order, then reads each completed bank back in bit-reversed order toward the downstream consumer, with `out_ready` backpressure. It is the consuming end of the `alert` chain that the `cu_mod*` stages produce.

## Interface
- `N_PTS`, 512, samples per frame (power of two)
- `ADDR_W`, 9, log2(N_PTS)
- `clk`  in  1  system clock, all logic on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `alert_in`  in  1  input sample valid this cycle, from last stage control unit
- `out_ready`  in  1  downstream accepts a sample this cycle
- `wr_en`  out  1  buffer write strobe (registered)
- `wr_addr`  out  ADDR_W  write address, natural order
- `wr_bank`  out  1  bank written
- `rd_en`  out  1  buffer read strobe (combinational from state and `out_ready`)
- `rd_addr`  out  ADDR_W  read address, bit-reversed read count
- `rd_bank`  out  1  bank read
- `dout_valid`  out  1  buffer read data valid; `rd_en` delayed 1 cycle for sync RAM
- `frame_done`  out  1  one-cycle pulse coincident with the last `dout_valid` of a frame
- `overflow`  out  1  sticky error: sample arrived while target bank full

## Operation
- Reset: all outputs 0; `wr_cnt`=0, `rd_cnt`=0, `full[1:0]`=0, state IDLE.
- Write side:
  - `wr_en <= alert_in & ~full[wr_bank]`.
  - `wr_addr` = `wr_cnt`, advancing by 1 on each cycle with `wr_en`=1.
  - On a write with `wr_cnt`=N_PTS-1: `wr_cnt`->0, `full[wr_bank]`<=1, `wr_bank` toggles.
  - `alert_in` gaps hold the count, so a frame may arrive non-contiguously.
- Overflow: `alert_in`=1 while `full[wr_bank]`=1 sets `overflow`. It stays set until reset. The sample is dropped and `wr_cnt` holds.
- Read FSM:
  - IDLE -> READ when `full[rd_bank]`=1.
  - In READ, `rd_en = out_ready` and `rd_addr = bitrev(rd_cnt)`; `rd_cnt` increments on `rd_en`.
  - A read with `rd_cnt`=N_PTS-1 clears `full[rd_bank]`, toggles `rd_bank`, resets `rd_cnt`, and returns to IDLE.
- `dout_valid <= rd_en`; `frame_done <= rd_en & (rd_cnt==N_PTS-1)`.
- Simultaneous events:
  - Write-side set and read-side clear of `full` always target different banks; both take effect in the same cycle.
  - A bank freed in cycle t is writable from t+1.
- Reset mid-operation discards any partial frame and buffered frames. There is no recovery state.

## Timing
- Write latency: `alert_in` high in cycle c gives `wr_en`=1 in c+1, with `wr_addr` as the count at that time.
- Let T be the cycle of the final write of bank b:
  - `full[b]`=1 at T+1.
  - State READ at T+2; first `rd_en` at T+2 if `out_ready`=1, with `rd_addr`=0.
  - First `dout_valid` at T+3.
- With `out_ready` held at 1, the frame reads out in 512 consecutive cycles. The last `rd_en` is at T+513; `dout_valid` and `frame_done` are both 1 at T+514.
- Back-to-back frames need no idle cycle on `alert_in` as long as reading keeps pace.
- `out_ready` low stalls reading with zero loss.

## Structure
- Shared package `fft_pkg`:
  - `N_PTS`, `ADDR_W` constants.
  - `rd_state_t` enum {IDLE, READ}.
  - `bitrev(logic [ADDR_W-1:0])` function, shared with other stages.
- Write counter: instance of the existing `addr_gen` (clk, rstn, en=`wr_en`), which wraps at N_PTS-1. The bank toggle and full flags stay in this block.
- The read counter and FSM are local. No other sub-module.

## Test plan
- Reset: hold `rstn`=0 with random inputs -> every output 0; after release, no activity until `alert_in`.
- Single frame, `out_ready`=1:
  - 512-cycle `alert_in` -> `wr_addr` 0..511 on bank 0.
  - `rd_addr` sequence 0, 256, 128, 384, 64 … 511 on bank 0.
  - Exactly one `frame_done`, at T+514.
- Back-to-back frames: 1024 contiguous `alert_in` cycles -> second frame written to bank 1 during bank 0 readout. Then `rd_bank`=1, two `frame_done` pulses, `overflow`=0.
- Backpressure and overflow:
  - `out_ready` high every other cycle -> readout takes 1023 cycles and `rd_addr` holds while stalled.
  - A third contiguous frame then sets `overflow`=1 and keeps `wr_en`=0 until a bank frees.
- Gapped input: `alert_in` low for 10 cycles at `wr_cnt`=200 -> `wr_addr` holds at 200, then resumes at 200; frame completes normally.
- Reset mid-read: `rstn` pulsed low at `rd_cnt`=100 -> state IDLE, `full`=0, `rd_addr`=0, no `frame_done`.
